// File: rtl/tdm_demux4_rx.sv
// tdm_demux4_rx: TDM receive demux, locks on frame sync and rebuilds the parallel word
//   clk, rst (async active-high), en (slot strobe), sync (slot-0 marker), serial_in (slot bit)
//   slot (next expected slot), word_out (last complete frame), word_valid / sync_err (1-cycle pulses), locked
module tdm_demux4_rx #(
   parameter int NCH   = 4,
   parameter int SEL_W = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             sync,
   input  logic             serial_in,
   output logic [SEL_W-1:0] slot,
   output logic [NCH-1:0]   word_out,
   output logic             word_valid,
   output logic             sync_err,
   output logic             locked
);
   typedef enum logic {HUNT, LOCKED} state_t;
   localparam logic [SEL_W-1:0] LAST = SEL_W'(NCH - 1);
   localparam logic [SEL_W-1:0] ONE  = SEL_W'(1);
   state_t           state_q, state_d;
   logic [SEL_W-1:0] slot_q, slot_d;
   logic [NCH-1:0]   shadow_q, shadow_d, word_q, word_d;
   logic             valid_q, valid_d, err_q, err_d;
   always_comb begin
      state_d  = state_q;
      slot_d   = slot_q;
      shadow_d = shadow_q;
      word_d   = word_q;
      valid_d  = 1'b0;
      err_d    = 1'b0;
      if (en) begin
         if (state_q == HUNT) begin
            if (sync) begin
               shadow_d = {serial_in, {(NCH-1){1'b0}}};
               slot_d   = ONE;
               state_d  = LOCKED;
            end
         end else if (sync) begin
            // any sync restarts the frame; only an off-slot-0 one is an error
            shadow_d = {serial_in, {(NCH-1){1'b0}}};
            slot_d   = ONE;
            err_d    = slot_q != '0;
         end else if (slot_q == '0) begin
            err_d   = 1'b1;
            state_d = HUNT;
         end else begin
            shadow_d[LAST - slot_q] = serial_in;
            slot_d = slot_q + 1'b1;
            if (slot_q == LAST) begin
               word_d  = {shadow_q[NCH-1:1], serial_in};
               valid_d = 1'b1;
            end
         end
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= HUNT;
         slot_q   <= '0;
         shadow_q <= '0;
         word_q   <= '0;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         slot_q   <= slot_d;
         shadow_q <= shadow_d;
         word_q   <= word_d;
         valid_q  <= valid_d;
         err_q    <= err_d;
      end
   end
   assign slot       = slot_q;
   assign word_out   = word_q;
   assign word_valid = valid_q;
   assign sync_err   = err_q;
   assign locked     = state_q == LOCKED;
endmodule

// File: tb/tb_tdm_demux4_rx.sv
// tb_tdm_demux4_rx: directed bench with a frame-queue reference model for tdm_demux4_rx
module tb_tdm_demux4_rx;
   logic       clk, rst, en, sync, serial_in;
   logic [1:0] slot;
   logic [3:0] word_out;
   logic       word_valid, sync_err, locked;
   tdm_demux4_rx #(.NCH(4), .SEL_W(2)) dut (
      .clk(clk), .rst(rst), .en(en), .sync(sync), .serial_in(serial_in),
      .slot(slot), .word_out(word_out), .word_valid(word_valid),
      .sync_err(sync_err), .locked(locked)
   );
   always #5 clk = ~clk;
   int npass = 0, ntot = 0;
   int cyc = 0, nvalid = 0, nerr = 0, last_v = 0, prev_v = 0;
   bit mlock = 0, mval = 0, merr = 0;
   logic [3:0] mword = 0;
   int mq[$];
   task automatic check(input string n, input logic [31:0] a, input logic [31:0] e);
      ntot++;
      if (a === e) npass++;
      else $display("FAIL %s actual=%h required=%h (t=%0t)", n, a, e, $time);
   endtask
   task automatic model_reset();
      mq.delete();
      mlock = 0; mval = 0; merr = 0; mword = 0;
   endtask
   task automatic model(input logic e, input logic s, input logic b);
      int w;
      mval = 0; merr = 0;
      if (!e) return;
      if (!mlock) begin
         if (s) begin mq = '{int'(b)}; mlock = 1; end
      end else if (s) begin
         merr = mq.size() != 0;
         mq = '{int'(b)};
      end else if (mq.size() == 0) begin
         merr = 1; mlock = 0;
      end else begin
         mq.push_back(int'(b));
         if (mq.size() == 4) begin
            w = 0;
            foreach (mq[i]) w = (w << 1) | mq[i];
            mword = 4'(w); mval = 1;
            mq.delete();
         end
      end
   endtask
   task automatic step(input logic e, input logic s, input logic b);
      en = e; sync = s; serial_in = b;
      @(posedge clk);
      cyc++;
      model(e, s, b);
      #1;
      check("cycle", {slot, word_out, word_valid, sync_err, locked},
            {2'(mq.size()), mword, mval, merr, mlock});
      nvalid += int'(word_valid);
      nerr   += int'(sync_err);
      if (word_valid) begin prev_v = last_v; last_v = cyc; end
   endtask
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'($urandom), 1'($urandom));
   endtask
   task automatic frame(input logic [3:0] w, input int gap);
      for (int i = 0; i < 4; i++) begin
         step(1'b1, i == 0, w[3-i]);
         idle(gap);
      end
   endtask
   initial begin
      clk = 0; rst = 1; en = 0; sync = 0; serial_in = 0;
      #12;
      check("reset_outputs", {slot, word_out, word_valid, sync_err, locked}, 0);
      @(negedge clk) rst = 0;
      // 1: single frame 1010, en held high
      nvalid = 0; nerr = 0;
      frame(4'b1010, 0);
      check("t1_valid_pulse", word_valid, 1);
      step(1'b0, 1'b0, 1'b0);
      check("t1_valid_drop", word_valid, 0);
      check("t1_word", word_out, 4'b1010);
      check("t1_nvalid", nvalid, 1);
      // 2: sparse strobe with noise between slots
      nvalid = 0; nerr = 0;
      frame(4'b0110, 2);
      idle(3);
      check("t2_word", word_out, 4'b0110);
      check("t2_nvalid", nvalid, 1);
      check("t2_nerr", nerr, 0);
      // 3: early sync discards partial frame
      nvalid = 0; nerr = 0;
      step(1'b1, 1'b1, 1'b1);
      step(1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b1);
      check("t3_err_pulse", sync_err, 1);
      check("t3_word_held", word_out, 4'b0110);
      step(1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      check("t3_word", word_out, 4'b1100);
      check("t3_nerr", nerr, 1);
      check("t3_nvalid", nvalid, 1);
      // 4: missing sync drops lock
      frame(4'b1010, 0);
      nvalid = 0; nerr = 0;
      step(1'b1, 1'b0, 1'b1);
      check("t4_err", sync_err, 1);
      check("t4_unlocked", locked, 0);
      step(1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1);
      check("t4_still_hunt", {locked, slot}, 0);
      check("t4_word_held", word_out, 4'b1010);
      check("t4_nerr", nerr, 1);
      // 5: async reset mid-frame
      frame(4'b1010, 0);
      step(1'b1, 1'b1, 1'b1);
      step(1'b1, 1'b0, 1'b0);
      check("t5_pre_slot", slot, 2);
      #1 rst = 1;
      #1;
      model_reset();
      check("t5_async_zero", {slot, word_out, word_valid, sync_err, locked}, 0);
      @(negedge clk) rst = 0;
      step(1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b1);
      check("t5_hunt", {locked, word_out}, 0);
      // 6: back-to-back frames
      nvalid = 0; nerr = 0;
      frame(4'b1010, 0);
      check("t6_word_a", word_out, 4'b1010);
      frame(4'b0101, 0);
      check("t6_word_b", word_out, 4'b0101);
      check("t6_spacing", last_v - prev_v, 4);
      check("t6_nvalid", nvalid, 2);
      check("t6_nerr", nerr, 0);
      idle(2);
      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end
endmodule
